// File: rtl/audio_pkg.sv
// Shared defaults and types for the audio frame statistics path.
package audio_pkg;

  localparam int unsigned DEF_IN_W      = 12;
  localparam int unsigned DEF_SAMPLE_W  = 8;
  localparam int unsigned DEF_FRAME_LEN = 256;
  localparam int unsigned DEF_OUT_W     = 24;

  typedef enum logic {
    IDLE,
    ACCUM
  } fa_state_t;

  // Sample counter width for a power-of-two frame length.
  function automatic int unsigned cnt_width(input int unsigned frame_len);
    return $clog2(frame_len);
  endfunction

endpackage

// File: rtl/sq_acc_stage.sv
// One statistics path: stage-1 sample (or square) register followed by a
// saturating stage-2 accumulator.
module sq_acc_stage #(
  parameter int unsigned SAMPLE_W = 8,
  parameter int unsigned OUT_W    = 24,
  parameter bit          SQUARE   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_load,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_add,
  input  logic                i_clr,
  output logic [OUT_W-1:0]    o_total
);

  localparam int unsigned SQ_W = 2 * SAMPLE_W;

  logic [SQ_W-1:0]  w_sq;
  logic [SQ_W-1:0]  r_s1;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W:0]   w_raw;

  assign w_sq = {{SAMPLE_W{1'b0}}, i_sample} * {{SAMPLE_W{1'b0}}, i_sample};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
    end else if (i_load) begin
      r_s1 <= SQUARE ? w_sq : {{SAMPLE_W{1'b0}}, i_sample};
    end
  end

  // Totals including the stage-1 value; clamps instead of wrapping.
  assign w_raw   = {1'b0, r_acc} + (OUT_W + 1)'(r_s1);
  assign o_total = w_raw[OUT_W] ? {OUT_W{1'b1}} : w_raw[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
    end else if (i_add) begin
      r_acc <= o_total;
    end
  end

endmodule

// File: rtl/frame_accumulator.sv
// Per-frame sum / sum-of-squares of truncated ADC samples with a registered
// valid/ready result that keeps accumulating while a result is pending.
module frame_accumulator
  import audio_pkg::*;
#(
  parameter int unsigned IN_W      = DEF_IN_W,
  parameter int unsigned SAMPLE_W  = DEF_SAMPLE_W,
  parameter int unsigned FRAME_LEN = DEF_FRAME_LEN,
  parameter int unsigned OUT_W     = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [IN_W-1:0]  sample_in,
  input  logic             sample_valid,
  output logic [OUT_W-1:0] sum,
  output logic [OUT_W-1:0] sum_sq,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CNT_W = cnt_width(FRAME_LEN);

  fa_state_t        r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_s1_valid;
  logic [OUT_W-1:0] r_sum, r_sum_sq;
  logic             r_out_valid, r_overrun;

  logic                w_add, w_last, w_clr;
  logic [SAMPLE_W-1:0] w_s;
  logic [OUT_W-1:0]    w_sum_total, w_sq_total;
  logic                w_unused_lsbs;

  assign w_s           = sample_in[IN_W-1 -: SAMPLE_W];
  assign w_unused_lsbs = ^sample_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_add        = 1'b0;
    w_last       = 1'b0;
    w_clr        = 1'b1;
    busy         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (en) w_state_next = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (!en) begin
          w_state_next = IDLE;
        end else begin
          w_add  = r_s1_valid;
          w_last = r_s1_valid && (r_cnt == CNT_W'(FRAME_LEN - 1));
          w_clr  = w_last;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Dropping en flushes stage 1 so a partial frame cannot leak into the next.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_s1_valid <= en && sample_valid;
      if (w_clr) begin
        r_cnt <= '0;
      end else if (w_add) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  sq_acc_stage #(
    .SAMPLE_W (SAMPLE_W),
    .OUT_W    (OUT_W),
    .SQUARE   (1'b0)
  ) u_sum_path (
    .clk      (clk),
    .rst      (rst),
    .i_load   (en && sample_valid),
    .i_sample (w_s),
    .i_add    (w_add),
    .i_clr    (w_clr),
    .o_total  (w_sum_total)
  );

  sq_acc_stage #(
    .SAMPLE_W (SAMPLE_W),
    .OUT_W    (OUT_W),
    .SQUARE   (1'b1)
  ) u_sq_path (
    .clk      (clk),
    .rst      (rst),
    .i_load   (en && sample_valid),
    .i_sample (w_s),
    .i_add    (w_add),
    .i_clr    (w_clr),
    .o_total  (w_sq_total)
  );

  // A completing frame wins over acceptance; overrun only if nobody took the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum       <= '0;
      r_sum_sq    <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (w_last) begin
      r_sum       <= w_sum_total;
      r_sum_sq    <= w_sq_total;
      r_out_valid <= 1'b1;
      if (r_out_valid && !out_ready) r_overrun <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign sum       = r_sum;
  assign sum_sq    = r_sum_sq;
  assign out_valid = r_out_valid;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_frame_accumulator.sv
// Scoreboard bench for frame_accumulator: expected frame totals are queued
// as samples are driven and popped when the frame result appears.
module tb_frame_accumulator;

  localparam int FRAME = 256;

  typedef struct packed {
    logic [23:0] sum;
    logic [23:0] sq;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [11:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic [23:0] sum, sum_sq;
  logic        out_valid, out_ready = 1'b1, overrun, busy;

  int   total = 0;
  int   bad = 0;
  int   busy_gap_err = 0;
  res_t sb[$];
  res_t e;

  frame_accumulator dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sum          (sum),
    .sum_sq       (sum_sq),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .overrun      (overrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: 12'h100, mode 1: 12'hFFF, mode 2: ramp s=i
  task automatic send_frame(input int mode, input bit gaps, input int n);
    logic [23:0] es, eq;
    logic [24:0] t;
    logic [15:0] sq;
    logic [11:0] v;
    logic [7:0]  s;
    int          g;
    es = '0;
    eq = '0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        g = $urandom_range(0, 3);
        sample_valid = 1'b0;
        for (int k = 0; k < g; k++) begin
          step();
          if (busy !== 1'b1) busy_gap_err++;
        end
      end
      case (mode)
        0:       v = 12'h100;
        1:       v = 12'hFFF;
        default: v = 12'(i << 4);
      endcase
      sample_in    = v;
      sample_valid = 1'b1;
      step();
      s  = v[11:4];
      sq = {8'h00, s} * {8'h00, s};
      t  = {1'b0, es} + 25'(s);
      es = t[24] ? 24'hFFFFFF : t[23:0];
      t  = {1'b0, eq} + 25'(sq);
      eq = t[24] ? 24'hFFFFFF : t[23:0];
    end
    sample_valid = 1'b0;
    if (n == FRAME) sb.push_back('{sum: es, sq: eq});
  endtask

  task automatic get_exp(output res_t r);
    if (sb.size() != 0) r = sb.pop_front();
    else r = '1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (sum !== 24'h0) begin bad++; $display("FAIL reset_sum got=%h want=0", sum); end
    total++; if (sum_sq !== 24'h0) begin bad++; $display("FAIL reset_sumsq got=%h want=0", sum_sq); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    en = 1'b1;
    out_ready = 1'b1;
    send_frame(0, 1'b0, FRAME);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_early got=%b want=0", out_valid); end
    step();
    get_exp(e);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b want=1", out_valid); end
    total++; if (sum !== e.sum) begin bad++; $display("FAIL b2b_sum got=%h want=%h", sum, e.sum); end
    total++; if (sum_sq !== e.sq) begin bad++; $display("FAIL b2b_sumsq got=%h want=%h", sum_sq, e.sq); end
    total++; if (sum !== 24'h001000) begin bad++; $display("FAIL b2b_sum_abs got=%h want=001000", sum); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_pulse got=%b want=0", out_valid); end
  endtask

  task automatic test_full_scale();
    send_frame(1, 1'b0, FRAME);
    step();
    get_exp(e);
    total++; if (sum !== e.sum) begin bad++; $display("FAIL fs_sum got=%h want=%h", sum, e.sum); end
    total++; if (sum_sq !== e.sq) begin bad++; $display("FAIL fs_sumsq got=%h want=%h", sum_sq, e.sq); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL fs_overrun got=%b want=0", overrun); end
    step();
  endtask

  task automatic test_ramp_gaps();
    busy_gap_err = 0;
    send_frame(2, 1'b1, FRAME);
    step();
    get_exp(e);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ramp_valid got=%b want=1", out_valid); end
    total++; if (sum !== e.sum) begin bad++; $display("FAIL ramp_sum got=%h want=%h", sum, e.sum); end
    total++; if (sum_sq !== e.sq) begin bad++; $display("FAIL ramp_sumsq got=%h want=%h", sum_sq, e.sq); end
    total++; if (busy_gap_err != 0) begin bad++; $display("FAIL ramp_busy lowcycles=%0d want=0", busy_gap_err); end
    step();
  endtask

  task automatic test_overrun();
    do_reset();
    en = 1'b1;
    out_ready = 1'b0;
    send_frame(2, 1'b0, FRAME);
    step();
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_first got=%b want=0", overrun); end
    send_frame(2, 1'b0, FRAME);
    step();
    get_exp(e);  // first frame was overwritten before acceptance
    get_exp(e);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", overrun); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b want=1", out_valid); end
    total++; if (sum !== e.sum) begin bad++; $display("FAIL ovr_sum2 got=%h want=%h", sum, e.sum); end
    send_frame(0, 1'b0, FRAME);
    step();
    get_exp(e);
    total++; if (sum !== e.sum) begin bad++; $display("FAIL ovr_sum3 got=%h want=%h", sum, e.sum); end
    total++; if (sum_sq !== e.sq) begin bad++; $display("FAIL ovr_sumsq3 got=%h want=%h", sum_sq, e.sq); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovr_accept got=%b want=0", out_valid); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", overrun); end
    total++; if (sum !== e.sum) begin bad++; $display("FAIL ovr_hold got=%h want=%h", sum, e.sum); end
  endtask

  task automatic test_same_edge();
    do_reset();
    en = 1'b1;
    out_ready = 1'b0;
    send_frame(0, 1'b0, FRAME);
    step();
    get_exp(e);
    total++; if (sum !== e.sum) begin bad++; $display("FAIL se_first got=%h want=%h", sum, e.sum); end
    send_frame(2, 1'b0, FRAME);
    out_ready = 1'b1;
    step();
    get_exp(e);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL se_valid got=%b want=1", out_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL se_overrun got=%b want=0", overrun); end
    total++; if (sum !== e.sum) begin bad++; $display("FAIL se_sum got=%h want=%h", sum, e.sum); end
    total++; if (sum_sq !== e.sq) begin bad++; $display("FAIL se_sumsq got=%h want=%h", sum_sq, e.sq); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL se_accept got=%b want=0", out_valid); end
  endtask

  task automatic test_en_abort();
    send_frame(1, 1'b0, 100);
    en = 1'b0;
    step();
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_valid got=%b want=0", out_valid); end
    // samples offered while disabled must not count
    sample_in = 12'hFFF;
    sample_valid = 1'b1;
    step();
    step();
    sample_valid = 1'b0;
    en = 1'b1;
    send_frame(0, 1'b0, FRAME);
    step();
    get_exp(e);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL abort_frame got=%b want=1", out_valid); end
    total++; if (sum !== e.sum) begin bad++; $display("FAIL abort_sum got=%h want=%h", sum, e.sum); end
    total++; if (sum_sq !== e.sq) begin bad++; $display("FAIL abort_sumsq got=%h want=%h", sum_sq, e.sq); end
    step();
  endtask

  task automatic test_rst_midframe();
    send_frame(1, 1'b0, 100);
    rst = 1'b1;
    step();
    total++; if (sum !== 24'h0) begin bad++; $display("FAIL rstmid_sum got=%h want=0", sum); end
    total++; if (sum_sq !== 24'h0) begin bad++; $display("FAIL rstmid_sumsq got=%h want=0", sum_sq); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid got=%b want=0", out_valid); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rstmid_overrun got=%b want=0", overrun); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
    rst = 1'b0;
    sb.delete();
    send_frame(0, 1'b0, FRAME);
    step();
    get_exp(e);
    total++; if (sum !== e.sum) begin bad++; $display("FAIL rstmid_after got=%h want=%h", sum, e.sum); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_scale();
    test_ramp_gaps();
    test_overrun();
    test_same_edge();
    out_ready = 1'b1;
    test_en_abort();
    test_rst_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
